dsp_mac_sequencer: RTL and testbench
====================================

DSP_MAC_SEQUENCER -- requirements
Module: dsp_mac_sequencer

Interface
REQ-001 SHALL have parameter LEN_W, default 8, meaning the width of the element-count input.
REQ-002 SHALL have ports `clk` (input, 1, sole clock, all state updates on rising edge) and `rst_n` (input, 1, asynchronous active-low reset).
REQ-003 SHALL have ports `start` (input, 1, begin job) and `len` (input, LEN_W, element count, sampled with `start`).
REQ-004 SHALL have ports `op_sub` (input, 1, subtract-accumulate select, sampled with `start`) and `busy` (output, 1, job in progress or result pending).
REQ-005 SHALL have ports `in_valid` (input, 1), `in_ready` (output, 1), `in_a` (input, 18) and `in_b` (input, 18), forming the operand stream.
REQ-006 SHALL have ports `dsp_a` (output, 18), `dsp_b` (output, 18), `dsp_opmode` (output, 8), `dsp_cea`, `dsp_ceb`, `dsp_cem`, `dsp_ceopmode` and `dsp_cep` (each output, 1), and `dsp_p` (input, 48), connecting to the DSP slice.
REQ-007 SHALL have ports `res_valid` (output, 1), `res_ready` (input, 1) and `res_data` (output, 48), forming the result handshake.

Function
REQ-008 SHALL drive a DSP slice configured with A1REG=1, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, A0REG=0, B0REG=0, CARRYINSEL=OPMODE5, B_INPUT=DIRECT.
REQ-009 SHALL implement the states IDLE, FEED, DRAIN and HOLD.
REQ-010 SHALL leave IDLE on `start`: to FEED when `len`≠0, or to HOLD with `res_data`=0 when `len`=0.
REQ-011 SHALL ignore `start` in any state other than IDLE.
REQ-012 SHALL assert `in_ready` only in FEED while the remaining count is nonzero; an element is accepted on any edge where `in_valid` and `in_ready` are both 1.
REQ-013 SHALL register `in_a` and `in_b` onto `dsp_a` and `dsp_b` on the accept edge.
REQ-014 SHALL decrement the remaining count on each accept and move FEED→DRAIN on the accept of the final element.
REQ-015 SHALL track accepted elements with a 3-stage valid/first tag pipeline aligned to the dsp_a, A1/B1 and M stages.
REQ-016 SHALL assert `dsp_cea` and `dsp_ceb` when the dsp_a stage tag is valid, and `dsp_cem` when the A1/B1 stage tag is valid.
REQ-017 SHALL assert `dsp_cep` when the M stage tag is valid; input bubbles therefore leave P unchanged.
REQ-018 SHALL hold `dsp_ceopmode`=1 while busy and present `dsp_opmode` one cycle ahead of the M stage it governs.
REQ-019 SHALL select the opmode by position and `op_sub`: first element 8'h01 (add) or 8'h81 (sub), X=M, Z=0; later elements 8'h09 (add) or 8'h89 (sub), X=M, Z=P.
REQ-020 SHALL use carry-in 0 (opmode[5]=0) and the pre-adder bypass (opmode[4]=0).
REQ-021 SHALL capture `dsp_p` into `res_data` 4 edges after the final accept edge, assert `res_valid` from that edge, and move to HOLD.
REQ-022 SHALL wrap `res_data` modulo 2^48 with no saturation.
REQ-023 SHALL hold `res_data` and `res_valid` stable in HOLD until `res_valid` and `res_ready` are both 1, then go to IDLE.
REQ-024 SHALL assert `busy` in FEED, DRAIN and HOLD.

Reset
REQ-025 SHALL, on `rst_n`=0 in any state including mid-job, immediately put the block in IDLE.
REQ-026 SHALL, on reset, clear all tags and counters and drive `in_ready`, `res_valid`, `busy` and every `dsp_ce*` to 0, `dsp_opmode` to 8'h00, and `dsp_a`, `dsp_b` and `res_data` to 0.
REQ-027 SHALL release reset without any spurious DSP enable, and SHALL discard any partial accumulation.

Structure
REQ-028 SHALL place the state enum, the opmode constants (FIRST_ADD=8'h01, ACC_ADD=8'h09, FIRST_SUB=8'h81, ACC_SUB=8'h89) and PIPE_LAT=4 in shared package dsp_seq_pkg.
REQ-029 SHALL implement the tag pipeline as sub-module dsp_tag_pipe (3-stage valid/first shift register with async active-low reset).

Verification
REQ-030 SHALL cover: len=4, add, pairs (1,2),(3,4),(5,6),(7,8), no bubbles → res_data=100, `res_valid` 4 edges after the last accept.
REQ-031 SHALL cover: len=3, op_sub=1, pairs (2,3),(4,5),(1,1) → res_data=-27 (48-bit two's complement).
REQ-032 SHALL cover: len=3 with `in_valid` low for 2 cycles between elements, pairs (10,10)×3 → 300, and `dsp_cep` low during the bubbles.
REQ-033 SHALL cover: len=0 → `res_valid` next edge with res_data=0, and `dsp_cep` never asserted.
REQ-034 SHALL cover: `res_ready` held low 5 cycles with a second `start` pulsed → result held, `start` ignored, IDLE entered only after the handshake.
REQ-035 SHALL cover: `rst_n` asserted after 2 of 4 accepts → all outputs at reset values; a new len=1 job with (3,3) → 9.

Source files
------------

// File: rtl/dsp_seq_pkg.sv
// Shared types and constants for the DSP MAC sequencer.
package dsp_seq_pkg;

   localparam int unsigned A_W       = 18;
   localparam int unsigned B_W       = 18;
   localparam int unsigned P_W       = 48;
   localparam int unsigned OPMODE_W  = 8;
   localparam int unsigned TAG_DEPTH = 3;

   // Edges from the final accept to the result capture:
   // dsp_a register, A1/B1, M, P.
   localparam int unsigned PIPE_LAT = 4;

   // Opmode layout: [7] post-adder subtract, [5] carry-in, [4] pre-adder,
   // [3:2] Z mux, [1:0] X mux.
   localparam logic [OPMODE_W-1:0] FIRST_ADD = 8'h01;
   localparam logic [OPMODE_W-1:0] ACC_ADD   = 8'h09;
   localparam logic [OPMODE_W-1:0] FIRST_SUB = 8'h81;
   localparam logic [OPMODE_W-1:0] ACC_SUB   = 8'h89;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } state_e;

   // First element clears the accumulator (Z=0); later ones add onto P.
   function automatic logic [OPMODE_W-1:0] opmode_sel(input logic first, input logic sub);
      logic [OPMODE_W-1:0] op;
      if (first) op = sub ? FIRST_SUB : FIRST_ADD;
      else       op = sub ? ACC_SUB   : ACC_ADD;
      return op;
   endfunction

endpackage

// File: rtl/dsp_tag_pipe.sv
// Valid/first tag shift register tracking accepted elements through the
// dsp_a, A1/B1 and M stages of the DSP slice.
module dsp_tag_pipe
   import dsp_seq_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic                 in_first,
   output logic [TAG_DEPTH-1:0] tag_valid,
   output logic [TAG_DEPTH-1:0] tag_first
);

   // Shift one stage per cycle; bubbles enter as invalid tags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_valid <= '0;
         tag_first <= '0;
      end else begin
         tag_valid <= {tag_valid[TAG_DEPTH-2:0], in_valid};
         tag_first <= {tag_first[TAG_DEPTH-2:0], in_valid & in_first};
      end
   end

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Sequences a multiply-accumulate job through a DSP slice configured with
// A1REG=B1REG=MREG=PREG=OPMODEREG=1, A0REG=B0REG=0, CARRYINSEL=OPMODE5,
// direct B input. Operands stream in, the sum of products (or its negation)
// is returned through a valid/ready result handshake.
module dsp_mac_sequencer
   import dsp_seq_pkg::*;
#(
   parameter int unsigned LEN_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [LEN_W-1:0]    len,
   input  logic                op_sub,
   output logic                busy,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [A_W-1:0]      in_a,
   input  logic [B_W-1:0]      in_b,
   output logic [A_W-1:0]      dsp_a,
   output logic [B_W-1:0]      dsp_b,
   output logic [OPMODE_W-1:0] dsp_opmode,
   output logic                dsp_cea,
   output logic                dsp_ceb,
   output logic                dsp_cem,
   output logic                dsp_ceopmode,
   output logic                dsp_cep,
   input  logic [P_W-1:0]      dsp_p,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [P_W-1:0]      res_data
);

   localparam int unsigned DRAIN_W = $clog2(PIPE_LAT);

   state_e               state_q, state_n;
   logic [LEN_W-1:0]     cnt_q, cnt_n;
   logic [DRAIN_W-1:0]   drain_q, drain_n;
   logic                 op_sub_q, op_sub_n;
   logic                 first_q, first_n;
   logic                 in_ready_n;
   logic                 res_valid_n;
   logic [P_W-1:0]       res_data_n;
   logic                 busy_n;
   logic                 accept_c;
   logic [TAG_DEPTH-1:0] tag_valid;
   logic [TAG_DEPTH-1:0] tag_first;
   logic                 unused_tag_first;

   assign accept_c = in_valid & in_ready;

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         drain_q   <= '0;
         op_sub_q  <= 1'b0;
         first_q   <= 1'b0;
         in_ready  <= 1'b0;
         res_valid <= 1'b0;
         res_data  <= '0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_n;
         cnt_q     <= cnt_n;
         drain_q   <= drain_n;
         op_sub_q  <= op_sub_n;
         first_q   <= first_n;
         in_ready  <= in_ready_n;
         res_valid <= res_valid_n;
         res_data  <= res_data_n;
         busy      <= busy_n;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_n     = state_q;
      cnt_n       = cnt_q;
      drain_n     = drain_q;
      op_sub_n    = op_sub_q;
      first_n     = first_q;
      res_valid_n = res_valid;
      res_data_n  = res_data;

      case (state_q)
         IDLE: begin
            if (start) begin
               op_sub_n = op_sub;
               first_n  = 1'b1;
               if (len != '0) begin
                  cnt_n   = len;
                  state_n = FEED;
               end else begin
                  res_data_n  = '0;
                  res_valid_n = 1'b1;
                  state_n     = HOLD;
               end
            end
         end
         FEED: begin
            if (accept_c) begin
               cnt_n   = cnt_q - LEN_W'(1);
               first_n = 1'b0;
               if (cnt_q == LEN_W'(1)) begin
                  drain_n = DRAIN_W'(PIPE_LAT - 1);
                  state_n = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (drain_q == '0) begin
               res_data_n  = dsp_p;
               res_valid_n = 1'b1;
               state_n     = HOLD;
            end else begin
               drain_n = drain_q - DRAIN_W'(1);
            end
         end
         HOLD: begin
            if (res_valid && res_ready) begin
               res_valid_n = 1'b0;
               state_n     = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase

      busy_n     = (state_n != IDLE);
      in_ready_n = (state_n == FEED) && (cnt_n != '0);
   end

   // Operand register in front of the DSP A1/B1 stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dsp_a <= '0;
         dsp_b <= '0;
      end else if (accept_c) begin
         dsp_a <= in_a;
         dsp_b <= in_b;
      end
   end

   // Opmode follows the element entering A1/B1 so the DSP opmode register
   // holds it while that element sits in M.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            dsp_opmode <= '0;
      else if (tag_valid[0]) dsp_opmode <= opmode_sel(tag_first[0], op_sub_q);
      else                   dsp_opmode <= '0;
   end

   dsp_tag_pipe u_tag_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (accept_c),
      .in_first  (first_q),
      .tag_valid (tag_valid),
      .tag_first (tag_first)
   );

   assign dsp_cea          = tag_valid[0];
   assign dsp_ceb          = tag_valid[0];
   assign dsp_cem          = tag_valid[1];
   assign dsp_cep          = tag_valid[2];
   assign dsp_ceopmode     = busy;
   assign unused_tag_first = ^tag_first[TAG_DEPTH-1:1];

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural DSP slice model.
module tb_dsp_mac_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  len;
   logic        op_sub;
   logic        busy;
   logic        in_valid;
   logic        in_ready;
   logic [17:0] in_a;
   logic [17:0] in_b;
   logic [17:0] dsp_a;
   logic [17:0] dsp_b;
   logic [7:0]  dsp_opmode;
   logic        dsp_cea, dsp_ceb, dsp_cem, dsp_ceopmode, dsp_cep;
   logic [47:0] dsp_p;
   logic        res_valid;
   logic        res_ready;
   logic [47:0] res_data;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   dsp_mac_sequencer #(.LEN_W(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .len          (len),
      .op_sub       (op_sub),
      .busy         (busy),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_a         (in_a),
      .in_b         (in_b),
      .dsp_a        (dsp_a),
      .dsp_b        (dsp_b),
      .dsp_opmode   (dsp_opmode),
      .dsp_cea      (dsp_cea),
      .dsp_ceb      (dsp_ceb),
      .dsp_cem      (dsp_cem),
      .dsp_ceopmode (dsp_ceopmode),
      .dsp_cep      (dsp_cep),
      .dsp_p        (dsp_p),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_data     (res_data)
   );

   // DSP slice model: A1/B1, M, OPMODE and P registers with clock enables.
   // P = Z +/- X with X=M when opmode[1:0]=01, Z=P when opmode[3:2]=10.
   logic signed [17:0] a1 = '0;
   logic signed [17:0] b1 = '0;
   logic signed [47:0] m  = '0;
   logic [7:0]         opreg = '0;
   logic [47:0]        p  = '0;
   logic [47:0]        mdl_x, mdl_z;

   assign mdl_x = (opreg[1:0] == 2'b01) ? 48'(m) : 48'd0;
   assign mdl_z = (opreg[3:2] == 2'b10) ? p : 48'd0;
   assign dsp_p = p;

   always @(posedge clk) begin
      if (dsp_cea) a1 <= dsp_a;
      if (dsp_ceb) b1 <= dsp_b;
      if (dsp_cem) m <= a1 * b1;
      if (dsp_ceopmode) opreg <= dsp_opmode;
      if (dsp_cep) p <= opreg[7] ? (mdl_z - mdl_x) : (mdl_z + mdl_x);
   end

   // Sticky record of any P enable while cep_watch is high.
   logic cep_watch = 1'b0;
   logic cep_mon   = 1'b0;
   always @(posedge clk) cep_mon <= cep_watch & (cep_mon | dsp_cep);

   task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input logic [7:0] l, input logic sub);
      start = 1'b1; len = l; op_sub = sub;
      tick();
      start = 1'b0; len = '0; op_sub = 1'b0;
   endtask

   // Present one operand pair and return just after its accept edge.
   task automatic send(input logic [17:0] a, input logic [17:0] b);
      int waited = 0;
      in_a = a; in_b = b; in_valid = 1'b1;
      while (!in_ready && waited < 20) begin
         tick();
         waited++;
      end
      check("send_ready", 48'(in_ready), 48'd1);
      tick();
      in_valid = 1'b0;
   endtask

   // After the final accept: result must appear on exactly the 4th edge.
   task automatic expect_result(input string tag, input logic [47:0] exp);
      tick(); tick(); tick();
      check({tag, "_early"}, 48'(res_valid), 48'd0);
      tick();
      check({tag, "_valid"}, 48'(res_valid), 48'd1);
      check({tag, "_data"}, res_data, exp);
   endtask

   task automatic handshake(input string tag);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check({tag, "_idle"}, {46'd0, busy, res_valid}, 48'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ce"}, 48'({dsp_cea, dsp_ceb, dsp_cem, dsp_ceopmode, dsp_cep}), 48'd0);
      check({tag, "_ctl"}, 48'({in_ready, res_valid, busy}), 48'd0);
      check({tag, "_opmode"}, 48'(dsp_opmode), 48'd0);
      check({tag, "_ab"}, 48'({dsp_a, dsp_b}), 48'd0);
      check({tag, "_res"}, res_data, 48'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; len = '0; op_sub = 1'b0;
      in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;

      // Reset values and clean release.
      tick(); tick();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick(); tick();
      check("release_ce", 48'({dsp_cea, dsp_cem, dsp_ceopmode, dsp_cep}), 48'd0);

      // len=4 add: 2+12+30+56 = 100.
      start_job(8'd4, 1'b0);
      check("t1_busy", 48'({busy, in_ready}), 48'b11);
      send(18'd1, 18'd2);
      check("t1_cea", 48'({dsp_cea, dsp_ceb}), 48'b11);
      check("t1_dsp_a", 48'(dsp_a), 48'd1);
      send(18'd3, 18'd4);
      check("t1_op_first", 48'(dsp_opmode), 48'h01);
      send(18'd5, 18'd6);
      check("t1_op_acc", 48'(dsp_opmode), 48'h09);
      send(18'd7, 18'd8);
      check("t1_ready_low", 48'(in_ready), 48'd0);
      expect_result("t1", 48'd100);
      handshake("t1");

      // len=3 subtract: -(6+20+1) = -27.
      start_job(8'd3, 1'b1);
      send(18'd2, 18'd3);
      send(18'd4, 18'd5);
      check("t2_op_first", 48'(dsp_opmode), 48'h81);
      send(18'd1, 18'd1);
      check("t2_op_acc", 48'(dsp_opmode), 48'h89);
      expect_result("t2", 48'hFFFF_FFFF_FFE5);
      handshake("t2");

      // len=3 with two-cycle bubbles: 3*100 = 300, P frozen in the gaps.
      start_job(8'd3, 1'b0);
      send(18'd10, 18'd10);
      tick(); tick();
      send(18'd10, 18'd10);
      check("t3_cep_bub1", 48'(dsp_cep), 48'd0);
      tick();
      check("t3_cep_bub2", 48'(dsp_cep), 48'd0);
      tick();
      check("t3_cep_elem1", 48'(dsp_cep), 48'd1);
      send(18'd10, 18'd10);
      expect_result("t3", 48'd300);
      handshake("t3");

      // len=0: result on the next edge, no P enable at all.
      cep_watch = 1'b1;
      start_job(8'd0, 1'b0);
      check("t4_valid", 48'(res_valid), 48'd1);
      check("t4_data", res_data, 48'd0);
      check("t4_ready", 48'(in_ready), 48'd0);
      handshake("t4");
      check("t4_cep_never", 48'(cep_mon | dsp_cep), 48'd0);
      cep_watch = 1'b0;

      // Result held under back-pressure; start in HOLD is ignored.
      start_job(8'd1, 1'b0);
      send(18'd4, 18'd5);
      expect_result("t5", 48'd20);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) start = 1'b1;
         len = 8'd2;
         tick();
         start = 1'b0;
      end
      len = '0;
      check("t5_held", {res_valid, 47'(res_data)}, {1'b1, 47'd20});
      check("t5_busy_ready", 48'({busy, in_ready}), 48'b10);
      handshake("t5");
      tick();
      check("t5_start_dropped", 48'({busy, in_ready}), 48'd0);

      // Reset mid-job, then a fresh len=1 job: 3*3 = 9.
      start_job(8'd4, 1'b0);
      send(18'd5, 18'd5);
      send(18'd6, 18'd6);
      tick(); tick(); tick();
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      tick();
      rst_n = 1'b1;
      tick();
      check("midrst_release", 48'({dsp_cea, dsp_cem, dsp_cep, busy}), 48'd0);
      start_job(8'd1, 1'b0);
      send(18'd3, 18'd3);
      expect_result("t6", 48'd9);
      handshake("t6");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
